alu_issue: RTL and testbench

- Sequencing front end that drives the 16-bit datapath ALU (the alu module) and collects its result and flags.
- Accepts an architectural operation (opcode plus two operands) over a valid/ready request handshake.
- Translates the operation into ALU control (Oper/invA/invB/Cin/sign), running one or two ALU passes.
- Returns the result and captured flags over a valid/ready response handshake. Sits between execute-stage control and the combinational ALU.

---
 rtl/alu_issue.sv | 218 +++++++++++++++++++++
 tb/tb_alu_issue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// alu_issue : request/response front end that drives the 16-bit alu in 1-2 passes
// Revision  : 1.0
// ============================================================================
module alu_issue #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [2:0]       resp_flags,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_InA,
  output logic [WIDTH-1:0] alu_InB,
  output logic             alu_Cin,
  output logic [3:0]       alu_Oper,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_Out,
  input  logic             alu_ZF,
  input  logic             alu_OF,
  input  logic             alu_SF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_XOR  = 4'b0010;
  localparam logic [3:0] c_OP_ANDN = 4'b0011;
  localparam logic [3:0] c_OP_ROL  = 4'b0100;
  localparam logic [3:0] c_OP_SLL  = 4'b0101;
  localparam logic [3:0] c_OP_ROR  = 4'b0110;
  localparam logic [3:0] c_OP_SRA  = 4'b0111;
  localparam logic [3:0] c_OP_SEQ  = 4'b1000;
  localparam logic [3:0] c_OP_SLT  = 4'b1001;
  localparam logic [3:0] c_OP_SLE  = 4'b1010;
  localparam logic [3:0] c_OP_SRL  = 4'b1011;

  localparam logic [3:0] c_ALU_ROL = 4'b0000;
  localparam logic [3:0] c_ALU_SLL = 4'b0001;
  localparam logic [3:0] c_ALU_SRA = 4'b0010;
  localparam logic [3:0] c_ALU_SRL = 4'b0011;
  localparam logic [3:0] c_ALU_ADD = 4'b0100;
  localparam logic [3:0] c_ALU_AND = 4'b0101;
  localparam logic [3:0] c_ALU_XOR = 4'b0111;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       amt_q, amt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             w_legal;
  logic             w_is_cmp;
  logic             w_cmp_bit;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_flags = flags_q;
  assign resp_err   = err_q;

  always_comb begin
    w_legal  = 1'b1;
    w_is_cmp = 1'b0;
    case (op_q)
      c_OP_SEQ, c_OP_SLT, c_OP_SLE: w_is_cmp = 1'b1;
      4'b1100, 4'b1101, 4'b1110, 4'b1111: w_legal = 1'b0;
      default: ;
    endcase
  end

  // Compare outcome from the A-B pass flags
  always_comb begin
    w_cmp_bit = 1'b0;
    case (op_q)
      c_OP_SEQ: w_cmp_bit = alu_ZF;
      c_OP_SLT: w_cmp_bit = alu_SF ^ alu_OF;
      c_OP_SLE: w_cmp_bit = (alu_SF ^ alu_OF) | alu_ZF;
      default:  w_cmp_bit = 1'b0;
    endcase
  end

  // ALU control; everything stays zero outside the execute states
  always_comb begin
    alu_InA  = '0;
    alu_InB  = '0;
    alu_Cin  = 1'b0;
    alu_Oper = 4'b0000;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b0;
    if (state_q == EXEC1) begin
      case (op_q)
        c_OP_ADD: begin
          alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_ADD; alu_sign = 1'b1;
        end
        c_OP_SUB: begin
          alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_ADD;
          alu_invA = 1'b1; alu_Cin = 1'b1; alu_sign = 1'b1;
        end
        c_OP_XOR: begin
          alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_XOR;
        end
        c_OP_ANDN: begin
          alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_AND; alu_invB = 1'b1;
        end
        c_OP_ROL: begin alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_ROL; end
        c_OP_SLL: begin alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_SLL; end
        c_OP_SRA: begin alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_SRA; end
        c_OP_SRL: begin alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_SRL; end
        c_OP_ROR: begin
          // -B: its low nibble is the equivalent left-rotate amount
          alu_InA = b_q; alu_Oper = c_ALU_ADD; alu_invA = 1'b1; alu_Cin = 1'b1;
        end
        c_OP_SEQ, c_OP_SLT, c_OP_SLE: begin
          alu_InA = a_q; alu_InB = b_q; alu_Oper = c_ALU_ADD;
          alu_invB = 1'b1; alu_Cin = 1'b1; alu_sign = 1'b1;
        end
        default: ;
      endcase
    end else if (state_q == EXEC2) begin
      alu_InA  = a_q;
      alu_InB  = {{(WIDTH-4){1'b0}}, amt_q};
      alu_Oper = c_ALU_ROL;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    amt_d   = amt_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = EXEC1;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
        end
      end
      EXEC1: begin
        if (op_q == c_OP_ROR) begin
          amt_d   = alu_Out[3:0];
          state_d = EXEC2;
        end else begin
          state_d = RESP;
          if (!w_legal) begin
            data_d  = '0;
            flags_d = 3'b000;
            err_d   = 1'b1;
          end else begin
            data_d  = w_is_cmp ? {{(WIDTH-1){1'b0}}, w_cmp_bit} : alu_Out;
            flags_d = {alu_ZF, alu_OF, alu_SF};
            err_d   = 1'b0;
          end
        end
      end
      EXEC2: begin
        data_d  = alu_Out;
        flags_d = {alu_ZF, alu_OF, alu_SF};
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      amt_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      amt_q   <= amt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// tb_alu_issue : scoreboard bench for alu_issue with a behavioural alu stand-in
// Revision     : 1.0
// ============================================================================
module tb_alu_issue;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  flags;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_flags;
  logic        resp_err;
  logic [15:0] alu_InA, alu_InB, alu_Out;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign;
  logic [3:0]  alu_Oper;
  logic        alu_ZF, alu_OF, alu_SF;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic rr_rand = 1'b0;
  logic rr_hold = 1'b1;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_InA(alu_InA), .alu_InB(alu_InB), .alu_Cin(alu_Cin), .alu_Oper(alu_Oper),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Out(alu_Out), .alu_ZF(alu_ZF), .alu_OF(alu_OF), .alu_SF(alu_SF)
  );

  // Behavioural alu: operand inversion first, then the selected operation
  logic [15:0] m_ai, m_bi;
  logic [16:0] m_sum;
  logic [31:0] m_w;
  always_comb begin
    m_ai    = alu_invA ? ~alu_InA : alu_InA;
    m_bi    = alu_invB ? ~alu_InB : alu_InB;
    m_sum   = {1'b0, m_ai} + {1'b0, m_bi} + {16'd0, alu_Cin};
    m_w     = {m_ai, m_ai} << m_bi[3:0];
    alu_Out = 16'h0000;
    alu_OF  = 1'b0;
    case (alu_Oper)
      4'b0000: alu_Out = m_w[31:16];
      4'b0001: alu_Out = m_ai << m_bi[3:0];
      4'b0010: alu_Out = $signed(m_ai) >>> m_bi[3:0];
      4'b0011: alu_Out = m_ai >> m_bi[3:0];
      4'b0100: begin
        alu_Out = m_sum[15:0];
        alu_OF  = alu_sign ? ((m_ai[15] == m_bi[15]) && (m_sum[15] != m_ai[15])) : m_sum[16];
      end
      4'b0101: alu_Out = m_ai & m_bi;
      4'b0110: alu_Out = m_ai | m_bi;
      4'b0111: alu_Out = m_ai ^ m_bi;
      default: alu_Out = 16'h0000;
    endcase
    alu_ZF = (alu_Out == 16'h0000);
    alu_SF = alu_Out[15];
  end

  // Architectural reference: what each opcode means, independent of pass structure
  function automatic exp_t ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          sa, sb, s, n;
    logic [31:0] w;
    logic [15:0] r, d;
    logic        ovf;
    sa = $signed(a); sb = $signed(b); n = int'(b[3:0]);
    s = 0; r = 16'h0; ovf = 1'b0; e = '0;
    case (op)
      4'd0:  begin s = sa + sb; r = s[15:0]; ovf = (s > 32767) || (s < -32768); end
      4'd1:  begin s = sb - sa; r = s[15:0]; ovf = (s > 32767) || (s < -32768); end
      4'd2:  r = a ^ b;
      4'd3:  r = a & ~b;
      4'd4:  begin w = {a, a} << n; r = w[31:16]; end
      4'd5:  r = a << n;
      4'd6:  begin w = {a, a} >> n; r = w[15:0]; end
      4'd7:  r = $signed(a) >>> n;
      4'd11: r = a >> n;
      4'd8, 4'd9, 4'd10: begin
        s = sa - sb; d = s[15:0]; ovf = (s > 32767) || (s < -32768);
        e.flags = {d == 16'h0, ovf, d[15]};
        if (op == 4'd8)      e.data = {15'd0, sa == sb};
        else if (op == 4'd9) e.data = {15'd0, sa < sb};
        else                 e.data = {15'd0, sa <= sb};
        return e;
      end
      default: begin e.err = 1'b1; return e; end
    endcase
    e.data  = r;
    e.flags = {r == 16'h0, ovf, r[15]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response consumer: random acceptance, or a held level when directed
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_hold;
    end
  end

  // Monitor: every completed response handshake is popped and compared
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {12'd0, resp_data, resp_flags, resp_err}, 32'hDEAD);
      end else begin
        chk("resp", {12'd0, resp_data, resp_flags, resp_err}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input exp_t e);
    bit done = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        done = 1;
      end
    end
    req_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  // Latency counted with the accept edge as edge 1
  task automatic wait_resp(input int lat);
    int cnt = 1;
    while (!resp_valid && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, lat);
  endtask

  initial begin
    logic [15:0] hd;
    logic [2:0]  hf;
    int          bad;
    logic [3:0]  op;
    logic [15:0] a, b;

    rst = 1'b1; req_valid = 1'b1; req_op = 4'd0; req_a = 16'h1; req_b = 16'h1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("reset_resp", {resp_valid, resp_data, resp_flags, resp_err}, 0);
    chk("reset_alu", {alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", req_ready, 1);

    send(4'd0, 16'h7FFF, 16'h0001, {16'h8000, 3'b011, 1'b0}); wait_resp(2);
    send(4'd1, 16'h0003, 16'h0010, {16'h000D, 3'b000, 1'b0}); wait_resp(2);
    send(4'd3, 16'hF0F0, 16'hFF00, {16'h00F0, 3'b000, 1'b0}); wait_resp(2);

    send(4'd6, 16'h0001, 16'h0001, {16'h8000, 3'b001, 1'b0});
    chk("ror_pass1_ctl", {alu_InA, alu_InB, alu_invA, alu_invB, alu_Cin, alu_Oper},
        {16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0100});
    chk("ror_pass1_out", alu_Out, 16'hFFFF);
    wait_resp(3);
    send(4'd6, 16'hBEEF, 16'h0010, {16'hBEEF, 3'b001, 1'b0}); wait_resp(3);

    send(4'd9,  16'h8000, 16'h0001, {16'h0001, 3'b010, 1'b0}); wait_resp(2);
    send(4'd9,  16'h0001, 16'h8000, {16'h0000, 3'b011, 1'b0}); wait_resp(2);
    send(4'd10, 16'h1234, 16'h1234, {16'h0001, 3'b100, 1'b0}); wait_resp(2);
    send(4'd8,  16'h1234, 16'h1235, {16'h0000, 3'b001, 1'b0}); wait_resp(2);
    send(4'd15, 16'h5555, 16'hAAAA, {16'h0000, 3'b000, 1'b1});
    chk("illegal_alu_idle", {alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign}, 0);
    wait_resp(2);

    // Backpressure: outputs hold and a pending request is refused
    @(posedge clk); #1;
    rr_hold = 1'b0;
    send(4'd0, 16'h1111, 16'h2222, ref_model(4'd0, 16'h1111, 16'h2222)); wait_resp(2);
    hd = resp_data; hf = resp_flags; bad = 0;
    req_valid = 1'b1; req_op = 4'd2; req_a = 16'hFFFF; req_b = 16'h0F0F;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_data !== hd || resp_flags !== hf || req_ready !== 1'b0 || resp_valid !== 1'b1) bad++;
    end
    chk("backpressure_hold", bad, 0);
    req_valid = 1'b0;
    rr_hold = 1'b1;

    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b[3:0] = 4'h0;
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      send(op, a, b, ref_model(op, a, b));
      wait_resp((op == 4'd6) ? 3 : 2);
    end
    rr_rand = 1'b0;

    // Reset during the second ROR pass abandons the operation
    bad = 0;
    while (resp_valid && bad < 20) begin @(posedge clk); #1; bad++; end
    send(4'd6, 16'h00F0, 16'h0004, ref_model(4'd6, 16'h00F0, 16'h0004));
    @(posedge clk); #1;
    chk("ror_pass2_ctl", {alu_InA, alu_Oper}, {16'h00F0, 4'b0000});
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midop_reset", {resp_valid, req_ready}, 2'b01);
    chk("midop_reset_alu", {alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign}, 0);
    bad = 0;
    repeat (8) begin @(negedge clk); if (resp_valid !== 1'b0) bad++; end
    chk("no_resp_after_reset", bad, 0);

    bad = 0;
    while (exp_q.size() != 0 && bad < 100) begin @(posedge clk); bad++; end
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
